// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: widths, FSM encodings and
// the round-robin grant identifiers.
package imem_dmem_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 32;
    localparam int SW   = XLEN / 8;

    // 3-bit FSM encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_D_REQ  = 3'd1;
    localparam logic [2:0] S_D_WAIT = 3'd2;
    localparam logic [2:0] S_I_REQ  = 3'd3;
    localparam logic [2:0] S_I_WAIT = 3'd4;

    // Identity of the requester that was granted most recently
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of the fetch port, the load/store port, the flush input, the
// memory port and the stall outputs.
//
// Handshake rules on every port of this bundle:
//   - A requester raises *_req with a stable payload and holds both until the
//     matching *_valid pulse; req still high in the cycle after valid is a
//     new request.
//   - m_req stays high with a stable payload until m_gnt is seen; m_rvalid
//     arrives at least one cycle after m_gnt, at most once per grant.
// The slave modport is the arbiter's view; master is the environment's view
// (pipeline plus memory).
interface imem_dmem_arbiter_if;
    import imem_dmem_arbiter_pkg::*;

    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_valid;
    logic [XLEN-1:0] if_rdata;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [SW-1:0]   d_wstrb;
    logic            d_valid;
    logic [XLEN-1:0] d_rdata;

    logic            flush;

    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_gnt;
    logic            m_rvalid;
    logic [XLEN-1:0] m_rdata;

    logic            stall_if;
    logic            stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, flush,
        input  m_gnt, m_rvalid, m_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, flush,
        output m_gnt, m_rvalid, m_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/imem_dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter between fetch and data. Grants only while
// enabled; on a tie the requester not granted last time wins.
module imem_dmem_arbiter_rr_arbiter2
    import imem_dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

    logic last_gnt;

    // Grant decision: single requester wins outright, tie goes to the other side
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (en) begin
            if (req_if && req_d) begin
                if (last_gnt == GNT_IF) gnt_d  = 1'b1;
                else                    gnt_if = 1'b1;
            end else begin
                gnt_if = req_if;
                gnt_d  = req_d;
            end
        end
    end

    // Remember the last winner; reset favours data on the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_gnt <= GNT_IF;
        else if (gnt_d)  last_gnt <= GNT_D;
        else if (gnt_if) last_gnt <= GNT_IF;
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction outstanding at a time; a fetch cancelled by flush still
// completes on the bus but its response is discarded. state and drop are
// brought out for observation.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    imem_dmem_arbiter_if.slave  bus,
    output logic [2:0]          state,
    output logic                drop
);

    logic            gnt_if;
    logic            gnt_d;
    logic            in_idle;
    logic            if_valid_w;
    logic            d_valid_w;
    logic            m_we_q;
    logic [AW-1:0]   m_addr_q;
    logic [XLEN-1:0] m_wdata_q;
    logic [SW-1:0]   m_wstrb_q;

    assign in_idle = (state == S_IDLE);

    // A fetch raised together with flush targets a stale PC, so it is not offered
    imem_dmem_arbiter_rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (reset),
        .en     (in_idle),
        .req_if (bus.if_req & ~bus.flush),
        .req_d  (bus.d_req),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    // Transaction FSM, payload capture on leaving IDLE, and flush tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            drop      <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_d) begin
                        state     <= S_D_REQ;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_wstrb_q <= bus.d_wstrb;
                    end else if (gnt_if) begin
                        state     <= S_I_REQ;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.if_addr;
                        m_wdata_q <= '0;
                        m_wstrb_q <= '0;
                    end
                end
                S_D_REQ: begin
                    if (bus.m_gnt) state <= S_D_WAIT;
                end
                S_D_WAIT: begin
                    if (bus.m_rvalid) state <= S_IDLE;
                end
                S_I_REQ: begin
                    if (bus.flush) drop <= 1'b1;
                    if (bus.m_gnt) state <= S_I_WAIT;
                end
                S_I_WAIT: begin
                    if (bus.m_rvalid) begin
                        drop  <= 1'b0;
                        state <= S_IDLE;
                    end else if (bus.flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response steering is a single gate level from m_rvalid
    assign d_valid_w  = (state == S_D_WAIT) & bus.m_rvalid;
    assign if_valid_w = (state == S_I_WAIT) & bus.m_rvalid & ~drop & ~bus.flush;

    // Memory port is driven purely from state and registers, never from m_gnt
    assign bus.m_req     = (state == S_D_REQ) | (state == S_I_REQ);
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_wstrb   = m_wstrb_q;

    assign bus.if_valid  = if_valid_w;
    assign bus.if_rdata  = bus.m_rdata;
    assign bus.d_valid   = d_valid_w;
    assign bus.d_rdata   = bus.m_rdata;

    assign bus.stall_if  = bus.if_req & ~if_valid_w;
    assign bus.stall_mem = bus.d_req & ~d_valid_w;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a small behavioural memory whose
// grant wait and response delay are set per step.
module tb_imem_dmem_arbiter;
    import imem_dmem_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic       drop;

    int tests = 0;
    int fails = 0;

    imem_dmem_arbiter_if bus ();

    imem_dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .state (state),
        .drop  (drop)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    int          gnt_wait;
    int          rv_delay;
    int          wait_cnt;
    int          pend_cnt;
    logic [7:0]  lat_idx;
    logic        extra_rv;

    assign bus.m_gnt    = bus.m_req && (wait_cnt >= gnt_wait);
    assign bus.m_rvalid = (pend_cnt == 1) || extra_rv;
    assign bus.m_rdata  = mem[lat_idx];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
            pend_cnt <= 0;
            lat_idx  <= 8'd0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
        end else begin
            if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
            if (bus.m_req && !bus.m_gnt) wait_cnt <= wait_cnt + 1;
            if (bus.m_gnt) begin
                wait_cnt <= 0;
                pend_cnt <= rv_delay;
                lat_idx  <= bus.m_addr[9:2];
                if (bus.m_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.m_wstrb[b]) mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset       = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        bus.flush   = 1'b0;
        gnt_wait    = 0;
        rv_delay    = 1;
        extra_rv    = 1'b0;
        tick();
        tick();

        // reset values
        chk("rst_state", state, S_IDLE);
        chk("rst_m_req", bus.m_req, 1'b0);
        chk("rst_m_we", bus.m_we, 1'b0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);
        chk("rst_m_wstrb", bus.m_wstrb, 4'h0);
        chk("rst_if_valid", bus.if_valid, 1'b0);
        chk("rst_d_valid", bus.d_valid, 1'b0);
        chk("rst_drop", drop, 1'b0);
        reset = 1'b0;
        tick();

        // 1: single load, zero-wait memory
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        #1;
        chk("t1_stall_n", bus.stall_mem, 1'b1);
        chk("t1_mreq_n", bus.m_req, 1'b0);
        tick();
        chk("t1_mreq_n1", bus.m_req, 1'b1);
        chk("t1_maddr_n1", bus.m_addr, 32'h100);
        chk("t1_stall_n1", bus.stall_mem, 1'b1);
        chk("t1_dvalid_n1", bus.d_valid, 1'b0);
        tick();
        chk("t1_dvalid_n2", bus.d_valid, 1'b1);
        chk("t1_rdata_n2", bus.d_rdata, 32'hA000_0040);
        chk("t1_stall_n2", bus.stall_mem, 1'b0);
        bus.d_req = 1'b0;
        tick();
        chk("t1_idle", state, S_IDLE);
        chk("t1_dvalid_pulse", bus.d_valid, 1'b0);

        // stray response while idle is ignored
        extra_rv = 1'b1;
        #1;
        chk("stray_dvalid", bus.d_valid, 1'b0);
        chk("stray_ifvalid", bus.if_valid, 1'b0);
        tick();
        extra_rv = 1'b0;
        chk("stray_state", state, S_IDLE);

        // 2: simultaneous requests after reset, both held
        reset = 1'b1;
        #1;
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.d_req  = 1'b1; bus.d_addr  = 32'h104;
        tick();
        chk("t2_g1_state", state, S_D_REQ);
        chk("t2_g1_addr", bus.m_addr, 32'h104);
        tick();
        chk("t2_dv1", bus.d_valid, 1'b1);
        chk("t2_dr1", bus.d_rdata, 32'hA000_0041);
        chk("t2_iv_early", bus.if_valid, 1'b0);
        chk("t2_stall_if", bus.stall_if, 1'b1);
        tick();
        chk("t2_idle1", state, S_IDLE);
        chk("t2_idle1_mreq", bus.m_req, 1'b0);
        tick();
        chk("t2_g2_addr", bus.m_addr, 32'h200);
        chk("t2_g2_we", bus.m_we, 1'b0);
        tick();
        chk("t2_iv1", bus.if_valid, 1'b1);
        chk("t2_ir1", bus.if_rdata, 32'hA000_0080);
        chk("t2_dv_quiet", bus.d_valid, 1'b0);
        tick();
        tick();
        chk("t2_g3_addr", bus.m_addr, 32'h104);
        tick();
        chk("t2_dv2", bus.d_valid, 1'b1);
        tick();
        tick();
        chk("t2_g4_addr", bus.m_addr, 32'h200);
        tick();
        chk("t2_iv2", bus.if_valid, 1'b1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
        chk("t2_end_state", state, S_IDLE);

        // 3: store with grant held off for three cycles
        gnt_wait = 3;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'hF;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t3_mreq", bus.m_req, 1'b1);
            chk("t3_gnt_low", bus.m_gnt, 1'b0);
            chk("t3_addr", bus.m_addr, 32'h10);
            chk("t3_wdata", bus.m_wdata, 32'hDEAD_BEEF);
            chk("t3_wstrb", bus.m_wstrb, 4'hF);
            chk("t3_we", bus.m_we, 1'b1);
            chk("t3_dvalid_wait", bus.d_valid, 1'b0);
            tick();
        end
        chk("t3_gnt", bus.m_gnt, 1'b1);
        tick();
        chk("t3_ack", bus.d_valid, 1'b1);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = 4'h0;
        gnt_wait = 0;
        tick();
        chk("t3_ack_pulse", bus.d_valid, 1'b0);
        bus.d_req = 1'b1; bus.d_addr = 32'h10;
        tick();
        tick();
        chk("t3_rb_valid", bus.d_valid, 1'b1);
        chk("t3_rb_data", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        tick();

        // 4: flush in I_WAIT, response two cycles later
        rv_delay = 3;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        tick();
        chk("t4_ireq", state, S_I_REQ);
        chk("t4_addr", bus.m_addr, 32'h300);
        tick();
        chk("t4_iwait", state, S_I_WAIT);
        bus.flush = 1'b1;
        #1;
        chk("t4_ifv_flush", bus.if_valid, 1'b0);
        tick();
        bus.flush = 1'b0;
        chk("t4_drop_set", drop, 1'b1);
        tick();
        chk("t4_dropped", bus.if_valid, 1'b0);
        chk("t4_stall_if", bus.stall_if, 1'b1);
        chk("t4_wait_state", state, S_I_WAIT);
        tick();
        chk("t4_back_idle", state, S_IDLE);
        chk("t4_drop_clr", drop, 1'b0);
        bus.if_addr = 32'h304;
        rv_delay = 1;
        tick();
        chk("t4_new_addr", bus.m_addr, 32'h304);
        tick();
        chk("t4_new_valid", bus.if_valid, 1'b1);
        chk("t4_new_data", bus.if_rdata, 32'hA000_00C1);
        bus.if_req = 1'b0;
        tick();

        // 5: flush coincident with the response
        bus.if_req = 1'b1; bus.if_addr = 32'h308;
        tick();
        tick();
        bus.flush = 1'b1;
        #1;
        chk("t5_ifv", bus.if_valid, 1'b0);
        chk("t5_stall_if", bus.stall_if, 1'b1);
        tick();
        bus.flush = 1'b0;
        chk("t5_drop", drop, 1'b0);
        chk("t5_idle", state, S_IDLE);
        tick();
        chk("t5_reissue", bus.m_addr, 32'h308);
        chk("t5_reissue_state", state, S_I_REQ);
        tick();
        chk("t5_valid", bus.if_valid, 1'b1);
        chk("t5_data", bus.if_rdata, 32'hA000_00C2);
        bus.if_req = 1'b0;
        tick();

        // 6: asynchronous reset while in D_WAIT
        rv_delay = 3;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h108;
        tick();
        tick();
        chk("t6_dwait", state, S_D_WAIT);
        reset = 1'b1;
        #1;
        chk("t6_async_state", state, S_IDLE);
        chk("t6_async_mreq", bus.m_req, 1'b0);
        chk("t6_async_addr", bus.m_addr, 32'h0);
        rv_delay = 1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rel_state", state, S_IDLE);
        tick();
        chk("t6_reissue_req", bus.m_req, 1'b1);
        chk("t6_reissue_addr", bus.m_addr, 32'h108);
        tick();
        chk("t6_valid", bus.d_valid, 1'b1);
        chk("t6_data", bus.d_rdata, 32'hA000_0042);
        bus.d_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
